map_sequencer: RTL and testbench
================================

MAP_SEQUENCER -- requirements
Module: map_sequencer

Interface
REQ-001 SHALL have parameter N, default 5, matrix row count.
REQ-002 SHALL have parameter M, default 5, matrix column count.
REQ-003 SHALL have parameter ROUNDS, default 24, mapper iterations per job (1..31).
REQ-004 SHALL have parameter CntBitCount, default 5, round counter width.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  job word offered.
REQ-008 SHALL have port in_ready  output  1  sequencer accepts a job.
REQ-009 SHALL have port in_data  input  N*M  job state, flattened row-major.
REQ-010 SHALL have port map_in  output  N*M  state driven into the external combinational mapper.
REQ-011 SHALL have port map_out  input  N*M  mapper result, same cycle.
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  consumer takes result.
REQ-014 SHALL have port out_data  output  N*M  final state.
REQ-015 SHALL have port round_idx  output  CntBitCount  current round number.
REQ-016 SHALL have port busy  output  1  high in RUN.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE, with a N*M-bit state register and a round counter.
REQ-018 SHALL drive in_ready high only in IDLE.
REQ-019 SHALL, in IDLE with in_valid high at a clk edge, load in_data into the state register, clear round_idx to 0 and enter RUN.
REQ-020 SHALL drive map_in from the state register continuously in all states.
REQ-021 SHALL, in RUN on each clk edge, load map_out into the state register and increment round_idx.
REQ-022 SHALL leave RUN for DONE on the edge where round_idx equals ROUNDS-1, so exactly ROUNDS mapper applications occur.
REQ-023 SHALL make latency from accepting edge to first out_valid high exactly ROUNDS cycles.
REQ-024 SHALL hold out_valid high and out_data (= state register) stable in DONE until out_ready is high.
REQ-025 SHALL return to IDLE on the edge where out_valid and out_ready are both high; out_data stays unchanged until the next accepted job.
REQ-026 SHALL ignore in_valid outside IDLE (no queuing); jobs offered while busy stay pending at the source.
REQ-027 SHALL ignore out_ready outside DONE.
REQ-028 SHALL freeze round_idx at ROUNDS-1 in DONE and clear it only on job acceptance.
REQ-029 SHALL compare round_idx at CntBitCount width with no wrap in a legal configuration; ROUNDS greater than 2**CntBitCount is illegal.

Reset
REQ-030 SHALL, on rst high, immediately and asynchronously enter IDLE and clear the state register, round_idx, out_valid, and busy to 0, and set in_ready to 1 once rst is low.
REQ-031 SHALL abandon any in-flight job when rst is asserted mid-RUN or mid-DONE, and SHALL NOT produce a result for it.

Configuration
REQ-032 SHALL support macro MAP_SEQ_EARLY_STOP_EN: when defined, in RUN, if map_out equals the state register (fixed point), it SHALL load map_out and enter DONE on that edge regardless of round_idx.
REQ-033 SHALL, without MAP_SEQ_EARLY_STOP_EN, always run exactly ROUNDS rounds, even when a fixed point is reached.

Verification
REQ-034 SHALL verify: ROUNDS=24, identity mapper, in_data=25'h1ABCDEF accepted -> out_valid rises exactly 24 cycles later with out_data=25'h1ABCDEF.
REQ-035 SHALL verify: ROUNDS=3, mapper=rotate-left-1, in_data=25'h0000001 -> out_data=25'h0000008, round_idx=2.
REQ-036 SHALL verify: out_ready held low for 10 cycles in DONE -> out_valid and out_data stable, in_ready low; out_ready high -> IDLE next cycle.
REQ-037 SHALL verify: rst pulsed at round 5 of 24 -> outputs 0 immediately, out_valid never rises, and the next job completes normally.
REQ-038 SHALL verify: in_valid held high throughout -> back-to-back jobs with exactly one IDLE cycle between DONE handshake and next acceptance.
REQ-039 SHALL verify: MAP_SEQ_EARLY_STOP_EN defined, identity mapper, ROUNDS=24 -> out_valid after 1 cycle; without the macro -> after 24 cycles.

Source files
------------

// File: rtl/map_sequencer.sv
// ---------------------------------------------------------------------------
// map_sequencer
//
// Drives a job word through an external combinational mapper a fixed number
// of times, then offers the final state on a valid/ready output.
//
// Flow: IDLE accepts a job (in_valid) and loads it. RUN feeds the state
// register through map_in/map_out once per clock. DONE holds the result
// until out_ready. One job is in flight at a time; there is no queuing.
//
// Parameters
//   N, M         matrix rows/columns; the state word is N*M bits, row-major
//   ROUNDS       mapper applications per job (1..31)
//   CntBitCount  round counter width; ROUNDS must not exceed 2**CntBitCount
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   job word offered
//   in_ready   sequencer accepts a job (high only in IDLE)
//   in_data    job state, N*M bits
//   map_in     state register, driven to the external mapper
//   map_out    mapper result for map_in, same cycle
//   out_valid  result available (DONE)
//   out_ready  consumer takes the result
//   out_data   final state (the state register)
//   round_idx  current round number
//   busy       high while in RUN
//
// Build option
//   MAP_SEQ_EARLY_STOP_EN  when defined, RUN ends as soon as the mapper
//                          reaches a fixed point (map_out == state).
// ---------------------------------------------------------------------------
module map_sequencer #(
    parameter int unsigned N           = 5,
    parameter int unsigned M           = 5,
    parameter int unsigned ROUNDS      = 24,
    parameter int unsigned CntBitCount = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*M-1:0]         in_data,
    output logic [N*M-1:0]         map_in,
    input  logic [N*M-1:0]         map_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*M-1:0]         out_data,
    output logic [CntBitCount-1:0] round_idx,
    output logic                   busy
);

    localparam int unsigned W = N * M;

    // Round index at which RUN performs its final mapper application.
    localparam logic [CntBitCount-1:0] LastRound = CntBitCount'(ROUNDS - 1);
    localparam logic [CntBitCount-1:0] RoundOne  = CntBitCount'(1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                 state_q;
    logic [W-1:0]           data_q;
    logic [CntBitCount-1:0] round_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;

    logic                   last_round;
    logic                   fixed_point;

    assign last_round = (round_q == LastRound);

`ifdef MAP_SEQ_EARLY_STOP_EN
    // Further rounds cannot change a fixed point, so stop early.
    assign fixed_point = (map_out == data_q);
`else
    assign fixed_point = 1'b0;
`endif

    // Single-process FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            data_q      <= '0;
            round_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        round_q    <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StRun;
                    end
                end

                StRun: begin
                    data_q <= map_out;
                    if (last_round || fixed_point) begin
                        // Counter freezes on the final round rather than
                        // stepping past ROUNDS-1.
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        round_q <= round_q + RoundOne;
                    end
                end

                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end

                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign map_in    = data_q;
    assign out_data  = data_q;
    assign out_valid = out_valid_q;
    assign round_idx = round_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_map_sequencer.sv
// ---------------------------------------------------------------------------
// tb_map_sequencer
//
// Directed bench for map_sequencer. Two instances share clk/rst:
//   dut_a  ROUNDS=24, mapper selectable between identity and rotate-left-1
//   dut_b  ROUNDS=3,  mapper fixed to rotate-left-1
// Expected values are hand-computed constants. Build with or without
// MAP_SEQ_EARLY_STOP_EN; identity-mapper expectations follow the macro.
// ---------------------------------------------------------------------------
module tb_map_sequencer;

    localparam int W = 25;

`ifdef MAP_SEQ_EARLY_STOP_EN
    localparam int IdLat   = 1;
    localparam int IdRound = 0;
`else
    localparam int IdLat   = 24;
    localparam int IdRound = 23;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    // dut_a
    logic         a_in_valid = 1'b0;
    logic         a_in_ready;
    logic [W-1:0] a_in_data = '0;
    logic [W-1:0] a_map_in;
    logic [W-1:0] a_map_out;
    logic         a_out_valid;
    logic         a_out_ready = 1'b0;
    logic [W-1:0] a_out_data;
    logic [4:0]   a_round_idx;
    logic         a_busy;
    logic         a_rot = 1'b0;

    // dut_b
    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic [W-1:0] b_in_data = '0;
    logic [W-1:0] b_map_in;
    logic [W-1:0] b_map_out;
    logic         b_out_valid;
    logic         b_out_ready = 1'b0;
    logic [W-1:0] b_out_data;
    logic [4:0]   b_round_idx;
    logic         b_busy;

    int n_checks = 0;
    int n_bad    = 0;

    assign a_map_out = a_rot ? {a_map_in[W-2:0], a_map_in[W-1]} : a_map_in;
    assign b_map_out = {b_map_in[W-2:0], b_map_in[W-1]};

    always #5 clk = ~clk;

    map_sequencer #(
        .N(5), .M(5), .ROUNDS(24), .CntBitCount(5)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (a_in_valid),
        .in_ready (a_in_ready),
        .in_data  (a_in_data),
        .map_in   (a_map_in),
        .map_out  (a_map_out),
        .out_valid(a_out_valid),
        .out_ready(a_out_ready),
        .out_data (a_out_data),
        .round_idx(a_round_idx),
        .busy     (a_busy)
    );

    map_sequencer #(
        .N(5), .M(5), .ROUNDS(3), .CntBitCount(5)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_data  (b_in_data),
        .map_in   (b_map_in),
        .map_out  (b_map_out),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_data (b_out_data),
        .round_idx(b_round_idx),
        .busy     (b_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one job to dut_a; returns #1 after the accepting edge.
    task automatic accept_a(input logic [W-1:0] d);
        a_in_data  = d;
        a_in_valid = 1'b1;
        step();
        a_in_valid = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid is seen, capped at 100.
    task automatic wait_valid_a(output int lat);
        lat = 0;
        while (!a_out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic wait_valid_b(output int lat);
        lat = 0;
        while (!b_out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    initial begin
        int  lat;
        logic seen;

        // Reset state, observed while rst is held.
        #12;
        check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);
        check_eq("rst_busy",      32'(a_busy),      32'd0);
        check_eq("rst_round_idx", 32'(a_round_idx), 32'd0);
        check_eq("rst_out_data",  32'(a_out_data),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_eq("idle_in_ready", 32'(a_in_ready),  32'd1);
        check_eq("idle_map_in",   32'(a_map_in),    32'd0);

        // Identity mapper, 24 rounds (1 with early stop).
        a_rot = 1'b0;
        accept_a(25'h1ABCDEF);
        check_eq("id_in_ready_run", 32'(a_in_ready), 32'd0);
        wait_valid_a(lat);
        check_eq("id_latency",   32'(lat),         32'(IdLat));
        check_eq("id_out_data",  32'(a_out_data),  32'h1ABCDEF);
        check_eq("id_round_idx", 32'(a_round_idx), 32'(IdRound));
        check_eq("id_busy_done", 32'(a_busy),      32'd0);

        // Hold off the consumer; result must stay put and no new job taken.
        a_in_data  = 25'h0055555;
        a_in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("hold_out_valid", 32'(a_out_valid), 32'd1);
            check_eq("hold_out_data",  32'(a_out_data),  32'h1ABCDEF);
            check_eq("hold_in_ready",  32'(a_in_ready),  32'd0);
        end
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        check_eq("hs_out_valid", 32'(a_out_valid), 32'd0);
        check_eq("hs_in_ready",  32'(a_in_ready),  32'd1);
        check_eq("hs_out_data",  32'(a_out_data),  32'h1ABCDEF);

        // dut_b: 3 rotations of 1 -> 8, round_idx frozen at 2.
        b_in_data  = 25'h0000001;
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        wait_valid_b(lat);
        check_eq("b_latency",   32'(lat),         32'd3);
        check_eq("b_out_data",  32'(b_out_data),  32'h0000008);
        check_eq("b_round_idx", 32'(b_round_idx), 32'd2);
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        check_eq("b_hs_in_ready", 32'(b_in_ready), 32'd1);

        // Reset in the middle of round 5.
        a_rot = 1'b1;
        accept_a(25'h0000001);
        for (int i = 0; i < 5; i++) step();
        check_eq("mid_round_idx", 32'(a_round_idx), 32'd5);
        check_eq("mid_busy",      32'(a_busy),      32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_busy",      32'(a_busy),      32'd0);
        check_eq("arst_round_idx", 32'(a_round_idx), 32'd0);
        check_eq("arst_out_data",  32'(a_out_data),  32'd0);
        check_eq("arst_out_valid", 32'(a_out_valid), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (a_out_valid) seen = 1'b1;
        end
        check_eq("arst_no_result", 32'(seen),       32'd0);
        check_eq("arst_in_ready",  32'(a_in_ready), 32'd1);

        // Job after reset: 24 rotate-left-1 of 1 lands on bit 24.
        accept_a(25'h0000001);
        wait_valid_a(lat);
        check_eq("post_latency",  32'(lat),        32'd24);
        check_eq("post_out_data", 32'(a_out_data), 32'h1000000);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;

        // Back-to-back with in_valid and out_ready held high.
        a_in_data   = 25'h0000001;
        a_in_valid  = 1'b1;
        a_out_ready = 1'b1;
        step();
        check_eq("b2b_accept1", 32'(a_busy), 32'd1);
        wait_valid_a(lat);
        check_eq("b2b_latency1",  32'(lat),        32'd24);
        check_eq("b2b_out_data1", 32'(a_out_data), 32'h1000000);
        step();
        check_eq("b2b_idle_valid", 32'(a_out_valid), 32'd0);
        check_eq("b2b_idle_ready", 32'(a_in_ready),  32'd1);
        step();
        check_eq("b2b_accept2_busy",  32'(a_busy),     32'd1);
        check_eq("b2b_accept2_ready", 32'(a_in_ready), 32'd0);
        wait_valid_a(lat);
        check_eq("b2b_latency2",  32'(lat),        32'd24);
        check_eq("b2b_out_data2", 32'(a_out_data), 32'h1000000);
        a_in_valid = 1'b0;
        step();
        a_out_ready = 1'b0;
        check_eq("b2b_final_valid", 32'(a_out_valid), 32'd0);
        step();
        check_eq("b2b_final_ready", 32'(a_in_ready), 32'd1);
        check_eq("b2b_final_busy",  32'(a_busy),     32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
